// File: rtl/hazard_forward_if.sv
// Bundle between the ID/EX/MEM/WB pipeline registers and the forwarding/hazard unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_forward_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) ();
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic [REG_W-1:0] rs_ex;
    logic [REG_W-1:0] rt_ex;
    logic [REG_W-1:0] rd_ex;
    logic             mem_read_ex;
    logic [REG_W-1:0] rd_mm;
    logic             wb_mm;
    logic [REG_W-1:0] rd_wb;
    logic             wb_wb;
    logic             flush;
    logic [1:0]       fwd_r1;
    logic [1:0]       fwd_r2;
    logic             stall;
    logic             bubble_ex;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    modport master (
        output rs_id, rt_id, rs_ex, rt_ex, rd_ex, mem_read_ex,
        output rd_mm, wb_mm, rd_wb, wb_wb, flush,
        input  fwd_r1, fwd_r2, stall, bubble_ex, stall_cnt, fwd_cnt
    );

    modport slave (
        input  rs_id, rt_id, rs_ex, rt_ex, rd_ex, mem_read_ex,
        input  rd_mm, wb_mm, rd_wb, wb_wb, flush,
        output fwd_r1, fwd_r2, stall, bubble_ex, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding (MEM over WB) and load-use stall FSM sized to the
// data-memory latency, with saturating stall/forward event counters.
module hazard_forward_unit #(
    parameter int REG_W    = 3,
    parameter int ZERO_REG = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_forward_if.slave  bus
);
    localparam int WC_W = $clog2(LOAD_LAT) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

    logic       lu;
    logic       stall_fsm;
    logic       stall_o;
    logic [1:0] fwd_r1, fwd_r2;

    // A write to the hard-wired zero register carries no usable value.
    function automatic logic hit(input logic we, input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] src);
        return we && (rd == src) && !((ZERO_REG != 0) && (rd == '0));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit(bus.wb_mm, bus.rd_mm, src))      sel = 2'b10;
        else if (hit(bus.wb_wb, bus.rd_wb, src)) sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        fwd_r1 = fwd_sel(bus.rs_ex);
        fwd_r2 = fwd_sel(bus.rt_ex);
    end

    always_comb begin
        lu = bus.mem_read_ex
           && ((bus.rd_ex == bus.rs_id) || (bus.rd_ex == bus.rt_id))
           && !((ZERO_REG != 0) && (bus.rd_ex == '0));
    end

    // The IDLE cycle that detects the hazard is the first stall cycle; WAIT
    // supplies the remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        stall_fsm = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall_fsm = lu;
                    if (lu && (LOAD_LAT > 1)) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WC_W'(LOAD_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    stall_fsm = 1'b1;
                    wcnt_d    = wcnt_q - WC_W'(1);
                    if (wcnt_q == WC_W'(1)) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    assign stall_o = stall_fsm && !rst;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (((fwd_r1 != 2'b00) || (fwd_r2 != 2'b00)) && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.fwd_r1    = fwd_r1;
    assign bus.fwd_r2    = fwd_r2;
    assign bus.stall     = stall_o;
    assign bus.bubble_ex = stall_o;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Drives three differently parameterised hazard units with shared stimulus and
// compares each against a cycle-level reference model.
module tb_hazard_forward_unit;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mm, rd_wb;
    logic mem_read_ex, wb_mm, wb_wb, flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_forward_if #(.REG_W(3), .CNT_W(16)) ifa ();
    hazard_forward_if #(.REG_W(3), .CNT_W(16)) ifb ();
    hazard_forward_if #(.REG_W(3), .CNT_W(4))  ifc ();

    assign ifa.rs_id = rs_id; assign ifa.rt_id = rt_id; assign ifa.rs_ex = rs_ex;
    assign ifa.rt_ex = rt_ex; assign ifa.rd_ex = rd_ex; assign ifa.mem_read_ex = mem_read_ex;
    assign ifa.rd_mm = rd_mm; assign ifa.wb_mm = wb_mm; assign ifa.rd_wb = rd_wb;
    assign ifa.wb_wb = wb_wb; assign ifa.flush = flush;
    assign ifb.rs_id = rs_id; assign ifb.rt_id = rt_id; assign ifb.rs_ex = rs_ex;
    assign ifb.rt_ex = rt_ex; assign ifb.rd_ex = rd_ex; assign ifb.mem_read_ex = mem_read_ex;
    assign ifb.rd_mm = rd_mm; assign ifb.wb_mm = wb_mm; assign ifb.rd_wb = rd_wb;
    assign ifb.wb_wb = wb_wb; assign ifb.flush = flush;
    assign ifc.rs_id = rs_id; assign ifc.rt_id = rt_id; assign ifc.rs_ex = rs_ex;
    assign ifc.rt_ex = rt_ex; assign ifc.rd_ex = rd_ex; assign ifc.mem_read_ex = mem_read_ex;
    assign ifc.rd_mm = rd_mm; assign ifc.wb_mm = wb_mm; assign ifc.rd_wb = rd_wb;
    assign ifc.wb_wb = wb_wb; assign ifc.flush = flush;

    hazard_forward_unit #(.REG_W(3), .ZERO_REG(1), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    hazard_forward_unit #(.REG_W(3), .ZERO_REG(1), .LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));
    hazard_forward_unit #(.REG_W(3), .ZERO_REG(0), .LOAD_LAT(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave));

    // Reference model: remaining stall cycles per hazard and plain saturating counts.
    int lat[3] = '{1, 3, 2};
    int zr[3]  = '{1, 1, 0};
    int mx[3]  = '{65535, 65535, 15};
    int rem[3], scnt[3], fcnt[3], est[3], efw[3];

    function automatic int exp_fwd(int z, logic [2:0] x);
        if (wb_mm && rd_mm == x && !(z != 0 && rd_mm == 0)) return 2;
        if (wb_wb && rd_wb == x && !(z != 0 && rd_wb == 0)) return 1;
        return 0;
    endfunction

    function automatic int exp_lu(int z);
        return (mem_read_ex && (rd_ex == rs_id || rd_ex == rt_id) && !(z != 0 && rd_ex == 0)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [1:0] f1, input logic [1:0] f2,
                             input logic st, input logic bb,
                             input logic [15:0] sc, input logic [15:0] fc);
        int e1, e2;
        e1 = exp_fwd(zr[k], rs_ex);
        e2 = exp_fwd(zr[k], rt_ex);
        if (rst || flush)    est[k] = 0;
        else if (rem[k] > 0) est[k] = 1;
        else                 est[k] = exp_lu(zr[k]);
        efw[k] = (e1 != 0 || e2 != 0) ? 1 : 0;
        chk($sformatf("dut%0d_fwd_r1", k), 32'(f1), e1);
        chk($sformatf("dut%0d_fwd_r2", k), 32'(f2), e2);
        chk($sformatf("dut%0d_stall", k), 32'(st), est[k]);
        chk($sformatf("dut%0d_bubble_ex", k), 32'(bb), est[k]);
        chk($sformatf("dut%0d_stall_cnt", k), 32'(sc), scnt[k]);
        chk($sformatf("dut%0d_fwd_cnt", k), 32'(fc), fcnt[k]);
    endtask

    task automatic check_all();
        check_dut(0, ifa.fwd_r1, ifa.fwd_r2, ifa.stall, ifa.bubble_ex, ifa.stall_cnt, ifa.fwd_cnt);
        check_dut(1, ifb.fwd_r1, ifb.fwd_r2, ifb.stall, ifb.bubble_ex, ifb.stall_cnt, ifb.fwd_cnt);
        check_dut(2, ifc.fwd_r1, ifc.fwd_r2, ifc.stall, ifc.bubble_ex,
                  16'(ifc.stall_cnt), 16'(ifc.fwd_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
            end else begin
                if (est[k] != 0 && scnt[k] < mx[k]) scnt[k]++;
                if (efw[k] != 0 && fcnt[k] < mx[k]) fcnt[k]++;
                if (flush)           rem[k] = 0;
                else if (rem[k] > 0) rem[k]--;
                else if (exp_lu(zr[k]) != 0) rem[k] = lat[k] - 1;
            end
        end
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        rs_id = 3'd1; rt_id = 3'd2; rs_ex = 3'd1; rt_ex = 3'd2; rd_ex = 3'd0;
        rd_mm = 3'd0; rd_wb = 3'd0;
        mem_read_ex = 1'b0; wb_mm = 1'b0; wb_wb = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin rem[k] = 0; scnt[k] = 0; fcnt[k] = 0; end
        idle_inputs();
        rst = 1'b1;
        sample(); tick();
        sample(); tick();
        rst = 1'b0;
        sample();
        chk("reset_stall_cnt", 32'(ifb.stall_cnt), 0);
        chk("reset_fwd_cnt", 32'(ifc.fwd_cnt), 0);
        tick();

        // MEM has priority over WB, then WB alone
        rs_ex = 3'd3; rd_mm = 3'd3; wb_mm = 1'b1; rd_wb = 3'd3; wb_wb = 1'b1;
        sample(); chk("mem_priority", 32'(ifa.fwd_r1), 2); tick();
        wb_mm = 1'b0;
        sample(); chk("wb_forward", 32'(ifa.fwd_r1), 1); tick();

        // Register 0 never forwards or stalls when hard-wired
        idle_inputs();
        rs_ex = 3'd0; rt_ex = 3'd0; rd_mm = 3'd0; wb_mm = 1'b1;
        mem_read_ex = 1'b1; rd_ex = 3'd0; rs_id = 3'd0;
        sample();
        chk("zero_fwd_r1", 32'(ifa.fwd_r1), 0);
        chk("zero_fwd_r2", 32'(ifa.fwd_r2), 0);
        chk("zero_stall", 32'(ifa.stall), 0);
        chk("nozero_fwd_r1", 32'(ifc.fwd_r1), 2);
        chk("nozero_stall", 32'(ifc.stall), 1);
        tick();
        idle_inputs();
        sample(); tick();
        sample(); tick();

        // Load-use hazard for one cycle: 1-cycle stall on A, 3-cycle on B
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        mem_read_ex = 1'b1; rd_ex = 3'd5; rt_id = 3'd5;
        sample();
        chk("lat1_stall", 32'(ifa.stall), 1);
        chk("lat1_bubble", 32'(ifa.bubble_ex), 1);
        chk("lat3_stall_c0", 32'(ifb.stall), 1);
        tick();
        idle_inputs();
        sample();
        chk("lat1_released", 32'(ifa.stall), 0);
        chk("lat3_stall_c1", 32'(ifb.stall), 1);
        tick();
        sample(); chk("lat3_stall_c2", 32'(ifb.stall), 1); tick();
        sample();
        chk("lat3_released", 32'(ifb.stall), 0);
        chk("lat3_stall_cnt", 32'(ifb.stall_cnt), 3);
        tick();

        // Flush in the second stall cycle aborts the stall
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        mem_read_ex = 1'b1; rd_ex = 3'd5; rt_id = 3'd5;
        sample(); tick();
        idle_inputs(); flush = 1'b1;
        sample(); chk("flush_stall", 32'(ifb.stall), 0); tick();
        flush = 1'b0;
        sample();
        chk("flush_idle", 32'(ifb.stall), 0);
        chk("flush_stall_cnt", 32'(ifb.stall_cnt), 1);
        tick();

        // Reset during WAIT leaves no residual stall
        mem_read_ex = 1'b1; rd_ex = 3'd4; rs_id = 3'd4;
        sample(); tick();
        idle_inputs(); rst = 1'b1;
        sample(); chk("rst_wait_stall", 32'(ifb.stall), 0); tick();
        rst = 1'b0;
        sample(); chk("rst_wait_release", 32'(ifb.stall), 0); tick();

        // Forward held for 20 cycles saturates the 4-bit counter
        rs_ex = 3'd6; rd_mm = 3'd6; wb_mm = 1'b1;
        for (int i = 0; i < 20; i++) begin sample(); tick(); end
        idle_inputs();
        sample();
        chk("fwd_cnt_sat", 32'(ifc.fwd_cnt), 15);
        chk("fwd_cnt_wide", 32'(ifa.fwd_cnt), 20);
        tick();
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        sample();
        chk("rst_fwd_cnt", 32'(ifc.fwd_cnt), 0);
        chk("rst_stall_cnt", 32'(ifc.stall_cnt), 0);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rs_id = 3'($urandom_range(0, 7)); rt_id = 3'($urandom_range(0, 7));
            rs_ex = 3'($urandom_range(0, 7)); rt_ex = 3'($urandom_range(0, 7));
            rd_ex = 3'($urandom_range(0, 7)); rd_mm = 3'($urandom_range(0, 7));
            rd_wb = 3'($urandom_range(0, 7));
            mem_read_ex = ($urandom_range(0, 2) == 0);
            wb_mm = $urandom_range(0, 1) == 1; wb_wb = $urandom_range(0, 1) == 1;
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            sample(); tick();
        end
        rst = 1'b0; idle_inputs();
        sample(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
